// File: rtl/vector_packer.sv
// vector_packer: serial-to-parallel lane packer feeding adder_tree.
// Collects one DWIDTH sample per valid cycle into a NUM_INPUTS-lane vector and
// emits it as a one-cycle pulse, either when full or when flushed (zero-padded).
module vector_packer #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DWIDTH-1:0]                i_dat,
  input  logic                             i_dat_valid,
  input  logic                             i_flush,
  output logic [NUM_INPUTS*DWIDTH-1:0]     o_dat_vector,
  output logic                             o_dat_valid,
  output logic                             o_dat_padded,
  output logic [$clog2(NUM_INPUTS):0]      o_fill
);

  localparam int CW = $clog2(NUM_INPUTS);
  localparam logic [CW-1:0] LAST_LANE = CW'(NUM_INPUTS - 1);

  logic [CW-1:0]                cnt;
  logic [NUM_INPUTS*DWIDTH-1:0] asm_q;
  logic [NUM_INPUTS*DWIDTH-1:0] asm_d;
  logic                         complete;
  logic                         flush_emit;
  logic                         emit;

  // Merge the incoming sample into its lane and decide whether this cycle emits.
  // Unfilled lanes are already zero because the assembly register is cleared on
  // every emit, so a flush needs no explicit masking.
  always_comb begin
    asm_d      = asm_q;
    complete   = 1'b0;
    flush_emit = 1'b0;
    if (i_dat_valid) begin
      asm_d[cnt*DWIDTH +: DWIDTH] = i_dat;
      complete = (cnt == LAST_LANE);
    end
    flush_emit = i_flush && ((cnt != '0) || i_dat_valid);
    emit       = complete || flush_emit;
  end

  // Lane counter, assembly register and registered output bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      asm_q        <= '0;
      o_dat_vector <= '0;
      o_dat_valid  <= 1'b0;
      o_dat_padded <= 1'b0;
    end else begin
      o_dat_valid  <= emit;
      o_dat_padded <= flush_emit && !complete;
      if (emit) begin
        o_dat_vector <= asm_d;
        asm_q        <= '0;
        cnt          <= '0;
      end else begin
        asm_q <= asm_d;
        if (i_dat_valid) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign o_fill = {1'b0, cnt};

endmodule

// File: tb/tb_vector_packer.sv
// Testbench for vector_packer: directed stimulus with a scoreboard of expected
// emits (vector, padded flag, cycle) checked by a monitor after each clock edge.
module tb_vector_packer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int N2 = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     i_dat = '0;
  logic              i_dat_valid = 1'b0;
  logic              i_flush = 1'b0;
  logic [N*DW-1:0]   o_dat_vector;
  logic              o_dat_valid;
  logic              o_dat_padded;
  logic [2:0]        o_fill;

  logic [DW-1:0]     i_dat2 = '0;
  logic              i_dat_valid2 = 1'b0;
  logic              i_flush2 = 1'b0;
  logic [N2*DW-1:0]  o_dat_vector2;
  logic              o_dat_valid2;
  logic              o_dat_padded2;
  logic [4:0]        o_fill2;

  typedef struct {
    logic [N*DW-1:0] vec;
    logic            pad;
    int              cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  vector_packer #(.NUM_INPUTS(N), .DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .i_dat(i_dat), .i_dat_valid(i_dat_valid),
    .i_flush(i_flush), .o_dat_vector(o_dat_vector), .o_dat_valid(o_dat_valid),
    .o_dat_padded(o_dat_padded), .o_fill(o_fill)
  );

  vector_packer #(.NUM_INPUTS(N2), .DWIDTH(DW)) dut16 (
    .clk(clk), .rst_n(rst_n), .i_dat(i_dat2), .i_dat_valid(i_dat_valid2),
    .i_flush(i_flush2), .o_dat_vector(o_dat_vector2), .o_dat_valid(o_dat_valid2),
    .o_dat_padded(o_dat_padded2), .o_fill(o_fill2)
  );

  always #5 clk = ~clk;

  // Monitor: every pulse must match the head of the scoreboard, on the expected cycle.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      assert (0) else begin
        errors++;
        $error("FAIL missed_pulse observed=none expected=%h at cycle %0d", q[0].vec, q[0].cyc);
      end
      void'(q.pop_front());
    end
    if (o_dat_valid === 1'b1) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pulse observed=%h expected=no pulse (cycle %0d)", o_dat_vector, cyc);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        assert (o_dat_vector === e.vec) else begin
          errors++;
          $error("FAIL vector observed=%h expected=%h", o_dat_vector, e.vec);
        end
        checks++;
        assert (o_dat_padded === e.pad) else begin
          errors++;
          $error("FAIL padded observed=%b expected=%b", o_dat_padded, e.pad);
        end
        checks++;
        assert (cyc === e.cyc) else begin
          errors++;
          $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus; optionally push the emit it should cause, then check o_fill.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic f,
                      input int exp_fill, input logic push,
                      input logic [N*DW-1:0] vec, input logic pad);
    exp_t e;
    @(negedge clk);
    i_dat_valid = v;
    i_dat       = d;
    i_flush     = f;
    if (push) begin
      e.vec = vec;
      e.pad = pad;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #3;
    check("fill", 128'(o_fill), 128'(exp_fill));
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [7:0] sum;
    // Reset state
    #1;
    check("reset_vec", 128'(o_dat_vector), 128'h0);
    check("reset_valid", 128'(o_dat_valid), 128'h0);
    check("reset_fill", 128'(o_fill), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full vector, fill sequence 1,2,3,0
    step(1'b1, 8'h01, 1'b0, 1, 1'b0, '0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 2, 1'b0, '0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 3, 1'b0, '0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 0, 1'b1, 32'h04030201, 1'b0);
    idle();
    check("hold_vec", 128'(o_dat_vector), 128'h04030201);
    check("hold_valid", 128'(o_dat_valid), 128'h0);

    // Back-to-back vectors, 4 cycles apart
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, (i + 1) % N, (i % N) == N - 1,
           (i < 4) ? 32'h13121110 : 32'h17161514, 1'b0);
    end
    idle();

    // Partial vector closed by a lone flush
    step(1'b1, 8'hAA, 1'b0, 1, 1'b0, '0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 2, 1'b0, '0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 1'b1, 32'h0000BBAA, 1'b1);
    idle();

    // Flush with a same-cycle sample that does not complete the vector
    step(1'b1, 8'h55, 1'b0, 1, 1'b0, '0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 0, 1'b1, 32'h00006655, 1'b1);

    // Flush coinciding with completion is a normal emit; lone flush on empty is a no-op
    step(1'b1, 8'h01, 1'b0, 1, 1'b0, '0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 2, 1'b0, '0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 3, 1'b0, '0, 1'b0);
    step(1'b1, 8'h04, 1'b1, 0, 1'b1, 32'h04030201, 1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 1'b0, '0, 1'b0);
    idle();

    // Partial vector discarded by reset
    step(1'b1, 8'h09, 1'b0, 1, 1'b0, '0, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 2, 1'b0, '0, 1'b0);
    @(negedge clk);
    i_dat_valid = 1'b0;
    i_flush     = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("rst_vec", 128'(o_dat_vector), 128'h0);
    check("rst_valid", 128'(o_dat_valid), 128'h0);
    check("rst_padded", 128'(o_dat_padded), 128'h0);
    check("rst_fill", 128'(o_fill), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h05, 1'b0, 1, 1'b0, '0, 1'b0);
    step(1'b1, 8'h06, 1'b0, 2, 1'b0, '0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 3, 1'b0, '0, 1'b0);
    step(1'b1, 8'h08, 1'b0, 0, 1'b1, 32'h08070605, 1'b0);
    idle();
    idle();

    // Default 16x8 configuration with samples 1..16, lane sum as adder_tree would see it
    for (int i = 1; i <= N2; i++) begin
      @(negedge clk);
      i_dat_valid2 = 1'b1;
      i_dat2       = 8'(i);
    end
    @(negedge clk);
    i_dat_valid2 = 1'b0;
    #1;
    check("v16_valid", 128'(o_dat_valid2), 128'h1);
    check("v16_padded", 128'(o_dat_padded2), 128'h0);
    check("v16_vec", o_dat_vector2, 128'h100F0E0D0C0B0A090807060504030201);
    sum = '0;
    for (int k = 0; k < N2; k++) sum = sum + o_dat_vector2[k*DW +: DW];
    check("v16_sum", 128'(sum), 128'h88);
    @(negedge clk);
    check("v16_pulse_len", 128'(o_dat_valid2), 128'h0);
    check("v16_fill", 128'(o_fill2), 128'h0);

    idle();
    check("scoreboard_empty", 128'(q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_packer.md
Name: vector_packer

Overview:
Serial-to-parallel packer that builds the packed NUM_INPUTS*DWIDTH lane vector consumed by adder_tree. It accepts one DWIDTH sample per valid cycle and emits a full vector as a one-cycle valid pulse. A flush request closes a partial vector and zero-pads the unfilled lanes. It sits directly upstream of adder_tree, and its output bundle connects 1:1 to that block's data-vector and data-valid inputs.

Parameters:
NUM_INPUTS, 16, lanes per vector; power of 2, >=2
DWIDTH, 8, bits per sample/lane

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk by system
i_dat  input  DWIDTH  sample
i_dat_valid  input  1  sample present this cycle; always accepted (no backpressure)
i_flush  input  1  close current partial vector
o_dat_vector  output  NUM_INPUTS*DWIDTH  packed vector; lane k = bits [k*DWIDTH +: DWIDTH]
o_dat_valid  output  1  one-cycle pulse, vector valid
o_dat_padded  output  1  qualifies o_dat_valid: vector was flushed with <NUM_INPUTS real lanes
o_fill  output  $clog2(NUM_INPUTS)+1  lanes currently held in assembly register

Behaviour:
- Reset (rst_n=0, async): o_dat_vector=0, o_dat_valid=0, o_dat_padded=0, o_fill=0, lane counter=0, assembly register=0. A partial vector in flight is discarded and never emitted.
- Lane order: first accepted sample after an emit or reset goes to lane 0, the next to lane 1, and so on. The counter increments by one per accepted sample.
- Accept, no completion (i_dat_valid=1, counter<NUM_INPUTS-1, i_flush=0): sample written to its lane; counter+1; no output.
- Completion (i_dat_valid=1, counter=NUM_INPUTS-1):
  - Next cycle: o_dat_vector = assembled lanes, with lane NUM_INPUTS-1 = this sample; o_dat_valid=1; o_dat_padded=0.
  - Counter and assembly register clear in the same edge.
  - Latency: 1 cycle from last sample to valid.
- Flush with partial data (i_flush=1 and (counter>0 or i_dat_valid=1)):
  - Any same-cycle sample is stored first.
  - Emit next cycle with all unfilled lanes = 0.
  - o_dat_padded=1 unless the same-cycle sample completed the vector; in that case it is a normal completion with padded=0.
  - Counter clears.
- Flush with nothing held (counter=0, i_dat_valid=0): no-op; no pulse.
- Back-to-back: a sample in the cycle immediately after completion or flush goes to lane 0 of the new vector. Sustained rate is one vector per NUM_INPUTS cycles, with no bubbles.
- o_dat_valid/o_dat_padded are high for exactly one cycle per emit. Between pulses, o_dat_vector holds the last emitted value (no glitching).
- o_fill tracks the counter (0..NUM_INPUTS-1). It reads 0 in the cycle after completion or flush.
- Width rules:
  - Samples are stored unmodified; no arithmetic.
  - Counter is $clog2(NUM_INPUTS) bits and wraps to 0 only via completion or flush, never via overflow.
  - o_fill is zero-extended by one bit.

Test Plan:
- NUM_INPUTS=4, DWIDTH=8; samples 0x01,0x02,0x03,0x04 on consecutive cycles -> one cycle after 0x04: o_dat_vector=0x04030201, o_dat_valid=1 for 1 cycle, o_dat_padded=0; o_fill sequence 0,1,2,3,0.
- 8 consecutive samples 0x10..0x17 -> two pulses, 4 cycles apart, with vectors 0x13121110 and 0x17161514; no dropped lanes.
- Samples 0xAA,0xBB, then i_flush alone -> next cycle vector 0x0000BBAA, valid=1, padded=1; o_fill returns to 0.
- 0x01,0x02,0x03, then 0x04 with i_flush in the same cycle -> vector 0x04030201, padded=0; a lone flush with o_fill=0 -> no pulse.
- Two samples, then rst_n low for 1 cycle, then 0x05..0x08 -> no pulse from the discarded partial; output 0x08070605 with padded=0. During reset, all outputs read 0.
- Output chained into adder_tree (16x8) with samples 1..16 -> adder_tree sum 0x88 (136 mod 256), sum-valid 4 cycles after the packer pulse.
